// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: register map and default sizing.
package pwm_pkg;

   localparam int unsigned DEF_WIDTH     = 16;
   localparam int unsigned DEF_CHANNELS  = 4;

   localparam int unsigned ADDR_TOP      = 0;
   localparam int unsigned ADDR_CNT      = 1;
   localparam int unsigned ADDR_POL      = 2;
   localparam int unsigned ADDR_CMP_BASE = 3;

endpackage : pwm_pkg

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: compare shadow/active pair and the output compare.
module pwm_cmp_ch
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_wrap,
   input  logic [WIDTH-1:0] i_cnt,
   input  logic             i_pol,
   output logic             o_out_c
);

   logic [WIDTH-1:0] r_cmp_sh;
   logic [WIDTH-1:0] r_cmp_act;
   logic [WIDTH-1:0] w_cmp_next;

   // A write landing in the wrap cycle goes straight through to the active copy.
   assign w_cmp_next = i_wr ? i_d : r_cmp_sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmp_sh  <= '0;
         r_cmp_act <= '0;
      end else begin
         if (i_wr)
            r_cmp_sh <= i_d;
         if (i_wrap)
            r_cmp_act <= w_cmp_next;
      end
   end

   assign o_out_c = (i_cnt < r_cmp_act) ^ i_pol;

endmodule : pwm_cmp_ch

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared counter with double-buffered TOP/POL/CMP registers.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter  int unsigned WIDTH    = DEF_WIDTH,
   parameter  int unsigned CHANNELS = DEF_CHANNELS,
   localparam int unsigned ADDR_W   = $clog2(CHANNELS + 3)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                wr,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [WIDTH-1:0]    d,
   output logic [WIDTH-1:0]    cnt,
   output logic [CHANNELS-1:0] out,
   output logic                period_end
);

   logic [WIDTH-1:0]    r_cnt;
   logic                r_period_end;
   logic [WIDTH-1:0]    r_top_sh;
   logic [WIDTH-1:0]    r_top_act;
   logic [CHANNELS-1:0] r_pol_sh;
   logic [CHANNELS-1:0] r_pol_act;

   logic                w_wr_top;
   logic                w_wr_cnt;
   logic                w_wr_pol;
   logic                w_wrap;
   logic [CHANNELS-1:0] w_out;

   assign w_wr_top = wr && (addr == ADDR_W'(ADDR_TOP));
   assign w_wr_cnt = wr && (addr == ADDR_W'(ADDR_CNT));
   assign w_wr_pol = wr && (addr == ADDR_W'(ADDR_POL));

   // A CNT write pre-empts the wrap so the written value is never lost.
   assign w_wrap = en && !w_wr_cnt && (r_cnt >= r_top_act);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_period_end <= 1'b0;
      end else if (w_wr_cnt) begin
         r_cnt        <= d;
         r_period_end <= 1'b0;
      end else if (w_wrap) begin
         r_cnt        <= '0;
         r_period_end <= 1'b1;
      end else if (en) begin
         r_cnt        <= r_cnt + WIDTH'(1);
         r_period_end <= 1'b0;
      end else begin
         r_period_end <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_top_sh  <= '0;
         r_top_act <= '0;
         r_pol_sh  <= '0;
         r_pol_act <= '0;
      end else begin
         if (w_wr_top)
            r_top_sh <= d;
         if (w_wr_pol)
            r_pol_sh <= d[CHANNELS-1:0];
         if (w_wrap) begin
            r_top_act <= w_wr_top ? d : r_top_sh;
            r_pol_act <= w_wr_pol ? d[CHANNELS-1:0] : r_pol_sh;
         end
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam int unsigned CH_ADDR = ADDR_CMP_BASE + i;
      logic w_wr_cmp;

      assign w_wr_cmp = wr && (addr == ADDR_W'(CH_ADDR));

      pwm_cmp_ch #(
         .WIDTH   (WIDTH)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_wr    (w_wr_cmp),
         .i_d     (d),
         .i_wrap  (w_wrap),
         .i_cnt   (r_cnt),
         .i_pol   (r_pol_act[i]),
         .o_out_c (w_out[i])
      );
   end

   assign cnt        = r_cnt;
   assign period_end = r_period_end;
   assign out        = w_out;

endmodule : pwm_multi

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus randomized traffic vs a register-map model.
module tb_pwm_multi;

   localparam int unsigned WIDTH    = 16;
   localparam int unsigned CHANNELS = 4;
   localparam int unsigned ADDR_W   = 3;

   logic                clk;
   logic                rst_n;
   logic                en;
   logic                wr;
   logic [ADDR_W-1:0]   addr;
   logic [WIDTH-1:0]    d;
   logic [WIDTH-1:0]    cnt;
   logic [CHANNELS-1:0] out;
   logic                period_end;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: shadow/active register file plus counter.
   logic [WIDTH-1:0]    m_cnt;
   logic                m_pe;
   logic [WIDTH-1:0]    m_top_sh, m_top_act;
   logic [CHANNELS-1:0] m_pol_sh, m_pol_act;
   logic [WIDTH-1:0]    m_cmp_sh  [CHANNELS];
   logic [WIDTH-1:0]    m_cmp_act [CHANNELS];

   pwm_multi #(
      .WIDTH      (WIDTH),
      .CHANNELS   (CHANNELS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .wr         (wr),
      .addr       (addr),
      .d          (d),
      .cnt        (cnt),
      .out        (out),
      .period_end (period_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [CHANNELS-1:0] m_out();
      logic [CHANNELS-1:0] o;
      for (int i = 0; i < CHANNELS; i++)
         o[i] = (m_cnt < m_cmp_act[i]) ^ m_pol_act[i];
      return o;
   endfunction

   task automatic model_reset();
      m_cnt = '0; m_pe = 1'b0;
      m_top_sh = '0; m_top_act = '0;
      m_pol_sh = '0; m_pol_act = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         m_cmp_sh[i]  = '0;
         m_cmp_act[i] = '0;
      end
   endtask

   // One clock edge of the register-map semantics.
   task automatic model_edge(input logic e, input logic w, input logic [ADDR_W-1:0] a,
                             input logic [WIDTH-1:0] dd);
      logic cw;
      logic wrap;
      int   ai;
      ai   = int'(a);
      cw   = w && (ai == 1);
      wrap = e && !cw && (m_cnt >= m_top_act);
      if (w) begin
         if (ai == 0) m_top_sh = dd;
         else if (ai == 2) m_pol_sh = dd[CHANNELS-1:0];
         else if (ai >= 3 && ai < 3 + CHANNELS) m_cmp_sh[ai-3] = dd;
      end
      if (wrap) begin
         m_top_act = m_top_sh;
         m_pol_act = m_pol_sh;
         for (int i = 0; i < CHANNELS; i++) m_cmp_act[i] = m_cmp_sh[i];
      end
      if (cw) begin
         m_cnt = dd; m_pe = 1'b0;
      end else if (!e) begin
         m_pe = 1'b0;
      end else if (wrap) begin
         m_cnt = '0; m_pe = 1'b1;
      end else begin
         m_cnt = WIDTH'((32'(m_cnt) + 1) % (1 << WIDTH));
         m_pe  = 1'b0;
      end
   endtask

   // Called just after a posedge; drives inputs, takes one edge, compares.
   task automatic step(input logic e, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [WIDTH-1:0] dd);
      en = e; wr = w; addr = a; d = dd;
      @(posedge clk);
      model_edge(e, w, a, dd);
      #1;
      check("cnt", 32'(cnt), 32'(m_cnt));
      check("period_end", 32'(period_end), 32'(m_pe));
      check("out", 32'(out), 32'(m_out()));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, '0);
   endtask

   task automatic run_until(input logic [WIDTH-1:0] tgt);
      int n;
      n = 0;
      while (m_cnt != tgt && n < 64) begin
         step(1'b1, 1'b0, '0, '0);
         n++;
      end
      check("run_until_cnt", 32'(cnt), 32'(tgt));
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      #1;
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_pe", 32'(period_end), 32'd0);
      check("rst_out", 32'(out), 32'd0);
      model_reset();
      en = 1'b0; wr = 1'b0; addr = '0; d = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      int hi0, hi1, hi2, pes;
      logic e, w;
      logic [ADDR_W-1:0] a;
      logic [WIDTH-1:0]  dd;

      rst_n = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; d = '0;
      model_reset();
      do_reset();

      // Basic PWM: TOP=9, CMP0=3
      step(1'b0, 1'b1, 3'd0, 16'd9);
      step(1'b0, 1'b1, 3'd3, 16'd3);
      run_until(16'd9);
      hi0 = 0; pes = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b0, '0, '0);
         hi0 += int'(out[0]); pes += int'(period_end);
      end
      check("duty3_high", 32'(hi0), 32'd3);
      check("duty3_pe", 32'(pes), 32'd1);

      // Shadow write mid-period keeps old duty until the wrap
      run_until(16'd4);
      step(1'b1, 1'b1, 3'd3, 16'd7);
      check("old_duty_out0", 32'(out[0]), 32'd0);
      run_until(16'd9);
      hi0 = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b0, '0, '0);
         hi0 += int'(out[0]);
      end
      check("duty7_high", 32'(hi0), 32'd7);

      // TOP write in the wrap cycle takes effect at that wrap
      run_until(16'd9);
      step(1'b1, 1'b1, 3'd0, 16'd4);
      check("wt_cnt", 32'(cnt), 32'd0);
      pes = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b0, '0, '0);
         pes += int'(period_end);
      end
      check("top4_pe", 32'(pes), 32'd2);

      // CNT write in a wrap cycle wins
      run_until(16'd4);
      step(1'b1, 1'b1, 3'd1, 16'd2);
      check("cntwr_cnt", 32'(cnt), 32'd2);
      check("cntwr_pe", 32'(period_end), 32'd0);

      // Boundaries: CMP1=0, CMP2=15 with TOP=9, POL=0001
      step(1'b1, 1'b1, 3'd0, 16'd9);
      step(1'b1, 1'b1, 3'd4, 16'd0);
      step(1'b1, 1'b1, 3'd5, 16'd15);
      step(1'b1, 1'b1, 3'd2, 16'd1);
      run_until(16'd9);
      hi0 = 0; hi1 = 0; hi2 = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 1'b0, '0, '0);
         hi0 += int'(out[0]); hi1 += int'(out[1]); hi2 += int'(out[2]);
      end
      check("pol_inv_out0", 32'(hi0), 32'd6);
      check("cmp0_out1", 32'(hi1), 32'd0);
      check("cmp_gt_top_out2", 32'(hi2), 32'd20);

      // Enable low freezes the counter
      run_until(16'd5);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, '0, '0);
         check("en0_cnt", 32'(cnt), 32'd5);
         check("en0_pe", 32'(period_end), 32'd0);
      end

      // Reset mid-period discards shadows; no wrap on release
      run_until(16'd3);
      step(1'b1, 1'b1, 3'd0, 16'd6);
      do_reset();
      step(1'b0, 1'b0, '0, '0);
      check("post_rst_out", 32'(out), 32'd0);
      step(1'b0, 1'b1, 3'd0, 16'd9);
      step(1'b0, 1'b1, 3'd3, 16'd5);
      step(1'b1, 1'b0, '0, '0);
      check("first_wrap_pe", 32'(period_end), 32'd1);
      check("first_wrap_out0", 32'(out[0]), 32'd1);
      idle(12);

      // Invalid address changes nothing
      step(1'b0, 1'b1, 3'd7, 16'hFFFF);
      idle(12);

      // Randomized traffic
      for (int k = 0; k < 2500; k++) begin
         e = ($urandom_range(0, 9) != 0);
         w = ($urandom_range(0, 3) == 0);
         a = ADDR_W'($urandom_range(0, 7));
         case (a)
            3'd0:    dd = WIDTH'($urandom_range(0, 20));
            3'd1:    dd = WIDTH'($urandom_range(0, 30));
            3'd2:    dd = WIDTH'($urandom);
            default: dd = WIDTH'($urandom_range(0, 24));
         endcase
         if ($urandom_range(0, 299) == 0) do_reset();
         else step(e, w, a, dd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pwm_multi

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter WIDTH, default 16: counter, top and compare width in bits.
REQ-002 Parameter CHANNELS, default 4: number of PWM outputs sharing one counter; legal range 1..16.
REQ-003 Derived ADDR_W = $clog2(CHANNELS+3), not overridable.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  count enable; 0 freezes counter and period logic.
REQ-007 wr  input  1  register write strobe.
REQ-008 addr  input  ADDR_W  write target: 0 TOP, 1 CNT, 2 POL, 3+i CMP[i].
REQ-009 d  input  WIDTH  write data; POL uses bits [CHANNELS-1:0].
REQ-010 cnt  output  WIDTH  current counter value.
REQ-011 out  output  CHANNELS  PWM outputs.
REQ-012 period_end  output  1  registered one-cycle pulse marking a counter wrap.

Function
REQ-013 Shadow registers top_sh, pol_sh and cmp_sh[i] take d on wr at their address in the same cycle, regardless of en.
REQ-014 Active registers top_act, pol_act and cmp_act[i] drive all comparisons and change only at a wrap.
REQ-015 Wrap condition: en=1, no CNT write this cycle, and cnt >= top_act.
REQ-016 On wrap, the block SHALL: set cnt <= 0; load every active register from its shadow; set period_end <= 1.
REQ-017 A shadow write in the wrap cycle takes effect in the active copy at that same wrap (write-through).
REQ-018 en=1, no wrap, no CNT write: cnt <= cnt+1, modulo 2^WIDTH.
REQ-019 en=0: cnt and the active registers hold, and period_end <= 0.
REQ-020 A CNT write sets cnt <= d immediately, overrides count and wrap that cycle, and forces period_end <= 0.
REQ-021 Writes to addresses >= CHANNELS+3 are ignored.
REQ-022 out[i] = (cnt < cmp_act[i]) XOR pol_act[i], combinational from registered state only.
REQ-023 Boundary values, with pol_act[i]=0:
 - cmp_act[i]=0: out[i] constantly 0.
 - cmp_act[i] > top_act: out[i] constantly 1.
REQ-024 Period length is top_act+1 cycles; top_act=0 gives cnt stuck at 0 and period_end high every enabled cycle.
REQ-025 A CNT write above top_act causes a wrap on the next enabled cycle; there is no count-through to 2^WIDTH.

Reset
REQ-026 While rst_n=0, the following SHALL be held at 0: cnt, period_end, all shadow registers and all active registers.
REQ-027 Consequence of REQ-026: out is all-zero during reset and in the first cycle after release.
REQ-028 Reset asserted mid-period SHALL discard pending shadow values; no wrap occurs on release.

Structure
REQ-029 A shared package pwm_pkg SHALL hold:
 - address constants ADDR_TOP=0, ADDR_CNT=1, ADDR_POL=2, ADDR_CMP_BASE=3;
 - default WIDTH and CHANNELS.
REQ-030 One sub-module, pwm_cmp_ch, SHALL hold one channel's cmp shadow/active pair and output compare; it is generated CHANNELS times.
REQ-031 Counter, TOP/POL registers and wrap logic SHALL reside in pwm_multi.

Verification
REQ-032 Basic PWM:
 - Stimulus: reset; write TOP=9, CMP0=3; en=1.
 - Response: after the first wrap, cnt cycles 0..9; out[0] is high for cnt 0..2 and low for 3..9; period_end pulses once per 10 cycles.
REQ-033 Shadow timing:
 - Stimulus: with TOP=9, write CMP0=7 at cnt=4.
 - Response: out[0] keeps the old duty until cnt returns to 0; duty is 7/10 from the next period.
REQ-034 Simultaneous events:
 - Stimulus: write TOP=4 in the cycle with cnt=9 (wrap cycle).
 - Response: the next period is 0..4.
 - Stimulus: CNT write of 2 in a wrap cycle.
 - Response: cnt=2, period_end=0.
REQ-035 Boundaries:
 - CMP1=0 -> out[1] always 0.
 - CMP2=15 with TOP=9 -> out[2] always 1.
 - POL=0b0001 applied at the next wrap -> out[0] inverted.
REQ-036 Enable and reset:
 - en=0 at cnt=5 for 3 cycles -> cnt holds at 5, period_end=0.
 - rst_n low mid-period -> all outputs 0 immediately (asynchronous).
 - After release: first count step follows only TOP/CMP rewrites plus a wrap.
REQ-037 Invalid address:
 - Stimulus: write addr = CHANNELS+3.
 - Response: no register changes.
